// File: rtl/fanout_mon_pkg.sv
// Shared types, default parameters and helpers for the fanout lane monitor.
package fanout_mon_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        FAULT  = 2'd3
    } mon_state_t;

    localparam int DEF_LANES         = 20;
    localparam int DEF_SETTLE_CYCLES = 2;
    localparam int DEF_ERR_THRESH    = 3;
    localparam int DEF_CNT_W         = 8;

    // popcount works on a fixed-width zero-padded vector so any lane count up to MAX_LANES fits
    localparam int MAX_LANES = 64;
    localparam int POP_W     = 7;

    function automatic logic [POP_W-1:0] popcount(input logic [MAX_LANES-1:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            n = n + POP_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/fanout_lane_run_counter.sv
// Per-lane saturating consecutive-mismatch counter with a sticky error bit.
module lane_run_counter
    import fanout_mon_pkg::*;
#(
    parameter int ERR_THRESH = DEF_ERR_THRESH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic check_en,
    input  logic mismatch,
    input  logic clr,
    output logic err
);

    localparam int            RW  = $clog2(ERR_THRESH + 1);
    localparam logic [RW-1:0] THR = RW'(ERR_THRESH);

    logic [RW-1:0] run;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run <= '0;
            err <= 1'b0;
        end else if (clr) begin
            run <= '0;
            err <= 1'b0;
        end else if (check_en) begin
            if (mismatch) begin
                if (run != THR) begin
                    run <= run + 1'b1;
                end
                // error latches on the edge where the run reaches the threshold
                if (run >= THR - 1'b1) begin
                    err <= 1'b1;
                end
            end else begin
                run <= '0;
            end
        end
    end

endmodule

// File: rtl/fanout_lane_monitor.sv
// Samples replicated fanout-tree lanes, majority-votes them and flags lanes
// that persistently disagree with the source net.
module fanout_lane_monitor
    import fanout_mon_pkg::*;
#(
    parameter int LANES         = DEF_LANES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int ERR_THRESH    = DEF_ERR_THRESH,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr_err,
    input  logic             src_in,
    input  logic [LANES-1:0] lanes,
    output logic             voted,
    output logic [LANES-1:0] lane_err,
    output logic             fault,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [1:0]       state_o
);

    localparam int               SW        = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0]    SETTLE_LD = SW'(SETTLE_CYCLES);
    localparam logic [POP_W-1:0] HALF      = POP_W'(LANES / 2);

    mon_state_t             state, state_nx;
    logic [SW-1:0]          settle_cnt, settle_nx;
    logic [LANES-1:0]       s1_lanes;
    logic                   s1_src, s2_src;
    logic                   src_edge, check_en;
    logic [LANES-1:0]       mism;
    logic [MAX_LANES-1:0]   lanes_pad;
    logic [POP_W-1:0]       pop;

    // Stage s1: input capture; s2 keeps the previous source for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_lanes <= '0;
            s1_src   <= 1'b0;
            s2_src   <= 1'b0;
        end else begin
            s1_lanes <= lanes;
            s1_src   <= src_in;
            s2_src   <= s1_src;
        end
    end

    always_comb begin
        lanes_pad              = '0;
        lanes_pad[LANES-1:0]   = s1_lanes;
        pop                    = popcount(lanes_pad);
        src_edge               = s1_src ^ s2_src;
        mism                   = s1_lanes ^ {LANES{s1_src}};
        check_en = ((state == CHECK) || (state == FAULT)) && !src_edge
                   && (settle_cnt == '0) && !clr_err;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
        end else begin
            state      <= state_nx;
            settle_cnt <= settle_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        settle_nx = settle_cnt;
        case (state)
            IDLE: begin
                if (en && !clr_err) begin
                    state_nx  = SETTLE;
                    settle_nx = SETTLE_LD;
                end
            end
            SETTLE: begin
                if (clr_err || src_edge) begin
                    settle_nx = SETTLE_LD;
                end else if (settle_cnt == SW'(1)) begin
                    state_nx  = CHECK;
                    settle_nx = '0;
                end else begin
                    settle_nx = settle_cnt - 1'b1;
                end
            end
            CHECK: begin
                if (clr_err) begin
                    state_nx  = SETTLE;
                    settle_nx = SETTLE_LD;
                end else if (|lane_err) begin
                    // FAULT keeps its own settle window if the edge coincides
                    state_nx  = FAULT;
                    settle_nx = src_edge ? SETTLE_LD : '0;
                end else if (src_edge) begin
                    state_nx  = SETTLE;
                    settle_nx = SETTLE_LD;
                end
            end
            FAULT: begin
                if (clr_err) begin
                    state_nx  = SETTLE;
                    settle_nx = SETTLE_LD;
                end else if (src_edge) begin
                    settle_nx = SETTLE_LD;
                end else if (settle_cnt != '0) begin
                    settle_nx = settle_cnt - 1'b1;
                end
            end
            default: begin
                state_nx  = IDLE;
                settle_nx = '0;
            end
        endcase
        if (!en) begin
            state_nx = IDLE;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        lane_run_counter #(
            .ERR_THRESH(ERR_THRESH)
        ) u_run (
            .clk      (clk),
            .rst_n    (rst_n),
            .check_en (check_en),
            .mismatch (mism[i]),
            .clr      (clr_err),
            .err      (lane_err[i])
        );
    end

    // Stage s2 outputs: vote and total mismatch count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            voted        <= 1'b0;
            mismatch_cnt <= '0;
        end else begin
            if (state != IDLE) begin
                if (pop > HALF) begin
                    voted <= 1'b1;
                end else if (pop < HALF) begin
                    voted <= 1'b0;
                end
            end
            if (clr_err) begin
                mismatch_cnt <= '0;
            end else if (check_en && (|mism) && (mismatch_cnt != '1)) begin
                mismatch_cnt <= mismatch_cnt + 1'b1;
            end
        end
    end

    assign fault   = |lane_err;
    assign state_o = state;

endmodule

// File: tb/tb_fanout_lane_monitor.sv
// Directed table-driven bench for fanout_lane_monitor with hand-computed expectations.
module tb_fanout_lane_monitor;

    localparam int LANES = 20;
    localparam int CNT_W = 8;
    localparam logic [LANES-1:0] ALL = 20'hFFFFF;

    typedef struct {
        logic             en;
        logic             clr;
        logic             src;
        logic [LANES-1:0] lanes;
        logic             exp_voted;
        logic [LANES-1:0] exp_err;
        logic [CNT_W-1:0] exp_cnt;
        logic [1:0]       exp_state;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n, en, clr_err, src_in;
    logic [LANES-1:0] lanes;
    logic             voted;
    logic [LANES-1:0] lane_err;
    logic             fault;
    logic [CNT_W-1:0] mismatch_cnt;
    logic [1:0]       state_o;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    fanout_lane_monitor #(
        .LANES(LANES), .SETTLE_CYCLES(2), .ERR_THRESH(3), .CNT_W(CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .clr_err      (clr_err),
        .src_in       (src_in),
        .lanes        (lanes),
        .voted        (voted),
        .lane_err     (lane_err),
        .fault        (fault),
        .mismatch_cnt (mismatch_cnt),
        .state_o      (state_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic e, input logic c, input logic s, input logic [LANES-1:0] l,
                       input logic v, input logic [LANES-1:0] er, input logic [CNT_W-1:0] cn,
                       input logic [1:0] st);
        vec_t r;
        r.en = e; r.clr = c; r.src = s; r.lanes = l;
        r.exp_voted = v; r.exp_err = er; r.exp_cnt = cn; r.exp_state = st;
        tbl.push_back(r);
    endtask

    task automatic chk_all(input string tag, input logic v, input logic [LANES-1:0] er,
                           input logic [CNT_W-1:0] cn, input logic [1:0] st);
        chk({tag, " voted"}, 32'(voted), 32'(v));
        chk({tag, " lane_err"}, 32'(lane_err), 32'(er));
        chk({tag, " fault"}, 32'(fault), 32'(er != '0));
        chk({tag, " mismatch_cnt"}, 32'(mismatch_cnt), 32'(cn));
        chk({tag, " state"}, 32'(state_o), 32'(st));
    endtask

    initial begin
        // reset with random lane/source activity
        rst_n = 1'b0; en = 1'b1; clr_err = 1'b0;
        src_in = 1'($urandom); lanes = LANES'($urandom);
        tick(); tick();
        chk_all("reset", 1'b0, '0, '0, 2'd0);

        rst_n = 1'b1; en = 1'b0; src_in = 1'b1; lanes = ALL;
        tick(); tick();
        chk_all("idle", 1'b0, '0, '0, 2'd0);

        //  en  clr src lanes      voted err       cnt  state
        add(1, 0, 1, ALL,       0, '0,        0, 1);
        add(1, 0, 1, ALL,       1, '0,        0, 1);
        add(1, 0, 1, ALL,       1, '0,        0, 2);
        add(1, 0, 1, ALL,       1, '0,        0, 2);
        add(1, 0, 1, 20'hFFFEF, 1, '0,        0, 2);
        add(1, 0, 1, 20'hFFFEF, 1, '0,        1, 2);
        add(1, 0, 1, ALL,       1, '0,        2, 2);
        add(1, 0, 1, ALL,       1, '0,        2, 2);
        add(1, 0, 1, ALL,       1, '0,        2, 2);
        add(1, 1, 1, ALL,       1, '0,        0, 1);
        add(1, 0, 1, ALL,       1, '0,        0, 1);
        add(1, 0, 1, ALL,       1, '0,        0, 2);
        add(1, 0, 1, 20'hFFF7F, 1, '0,        0, 2);
        add(1, 0, 1, 20'hFFF7F, 1, '0,        1, 2);
        add(1, 0, 1, 20'hFFF7F, 1, '0,        2, 2);
        add(1, 0, 1, ALL,       1, 20'h00080, 3, 2);
        add(1, 0, 1, ALL,       1, 20'h00080, 3, 3);
        add(1, 0, 1, ALL,       1, 20'h00080, 3, 3);
        add(1, 1, 1, ALL,       1, '0,        0, 1);
        add(1, 0, 1, ALL,       1, '0,        0, 1);
        add(1, 0, 1, ALL,       1, '0,        0, 2);
        add(1, 0, 0, ALL,       1, '0,        0, 2);
        add(1, 0, 0, '0,        1, '0,        0, 1);
        add(1, 0, 0, '0,        0, '0,        0, 1);
        add(1, 0, 0, '0,        0, '0,        0, 2);
        add(1, 0, 0, '0,        0, '0,        0, 2);
        add(1, 0, 1, '0,        0, '0,        0, 2);
        add(1, 0, 1, ALL,       0, '0,        0, 1);
        add(1, 0, 0, ALL,       1, '0,        0, 1);
        add(1, 0, 0, '0,        1, '0,        0, 1);
        add(1, 0, 0, '0,        0, '0,        0, 1);
        add(1, 0, 0, '0,        0, '0,        0, 2);
        add(1, 0, 0, 20'h007FF, 0, '0,        0, 2);
        add(1, 0, 0, 20'h003FF, 1, '0,        1, 2);
        add(1, 0, 0, 20'h003FF, 1, '0,        2, 2);
        add(1, 0, 0, '0,        1, 20'h003FF, 3, 2);
        add(1, 0, 0, '0,        0, 20'h003FF, 3, 3);
        add(1, 0, 0, 20'hFFC00, 0, 20'h003FF, 3, 3);
        add(1, 0, 0, '0,        0, 20'h003FF, 4, 3);
        add(1, 0, 0, '0,        0, 20'h003FF, 4, 3);
        add(0, 1, 0, '0,        0, '0,        0, 0);
        add(0, 0, 0, '0,        0, '0,        0, 0);

        foreach (tbl[i]) begin
            en = tbl[i].en; clr_err = tbl[i].clr; src_in = tbl[i].src; lanes = tbl[i].lanes;
            tick();
            chk_all($sformatf("row%0d", i), tbl[i].exp_voted, tbl[i].exp_err,
                    tbl[i].exp_cnt, tbl[i].exp_state);
        end

        // every lane disagrees with the source long enough to saturate the counter
        en = 1'b1; clr_err = 1'b0; src_in = 1'b0; lanes = ALL;
        for (int k = 0; k < 200; k++) tick();
        chk_all("sat200", 1'b1, ALL, 8'd197, 2'd3);
        for (int k = 0; k < 110; k++) tick();
        chk_all("sat310", 1'b1, ALL, 8'd255, 2'd3);

        // reset mid-operation discards sticky state
        rst_n = 1'b0;
        tick();
        chk_all("midreset", 1'b0, '0, '0, 2'd0);
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
